// File: rtl/cache_write_buffer_if.sv
// cache_write_buffer_if
//   Groups the cache-side request port and the memory-side request/ack
//   port of the cache write buffer.
//   Cache side : read_req, write_req, addr, wdata -> rdata, rvalid,
//                wr_stall, wb_empty
//   Memory side: mem_req, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_ack
//   slave  : view taken by the write buffer itself
//   master : view taken by the environment (cache + memory)
interface cache_write_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              read_req;
    logic              write_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              wr_stall;
    logic              wb_empty;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  read_req, write_req, addr, wdata, mem_rdata, mem_ack,
        output rdata, rvalid, wr_stall, wb_empty,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output read_req, write_req, addr, wdata, mem_rdata, mem_ack,
        input  rdata, rvalid, wr_stall, wb_empty,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_write_buffer.sv
// cache_write_buffer
//   Write-through buffer between the cache controller and main memory.
//   Cache writes are absorbed into a DEPTH-entry FIFO and drained to memory
//   one at a time; read misses take priority over draining and are
//   forwarded from the buffer when they hit a buffered (or same-cycle) write.
//   At most one memory access is outstanding.
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : cache_write_buffer_if.slave (cache request port + memory port)
module cache_write_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_write_buffer_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_ent_addr [DEPTH];
    logic [DATA_W-1:0] r_ent_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] w_mem_wdata_nxt;

    logic              w_full;
    logic              w_accept;
    logic              w_deq;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign w_full   = (r_count == FULL_COUNT);
    assign w_accept = bus.write_req && !w_full;
    // An entry leaves the buffer only once memory acknowledges its write.
    assign w_deq    = (r_state == WRITE) && bus.mem_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_deq) begin
                r_head          <= r_head + 1'b1;
                r_valid[r_head] <= 1'b0;
            end
            if (w_accept) begin
                r_tail          <= r_tail + 1'b1;
                r_valid[r_tail] <= 1'b1;
            end
            case ({w_accept, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload needs no reset: r_valid qualifies every use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ent_addr[r_tail] <= bus.addr;
            r_ent_data[r_tail] <= bus.wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read forwarding
    // Entries are scanned oldest (head) to youngest, so a later match
    // overrides an earlier one; a write accepted this same cycle is the
    // youngest of all and is checked last.
    // ------------------------------------------------------------------
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (r_valid[r_head + PW'(k)] &&
                (r_ent_addr[r_head + PW'(k)] == bus.addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_ent_data[r_head + PW'(k)];
            end
        end
        if (w_accept) begin
            // The write shares the request address, so it always matches.
            w_fwd_hit  = 1'b1;
            w_fwd_data = bus.wdata;
        end
    end

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rdata     <= w_rdata_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rdata_nxt     = r_rdata;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        case (r_state)
            IDLE: begin
                if (bus.read_req) begin
                    if (w_fwd_hit) begin
                        w_rdata_nxt = w_fwd_data;
                        w_state_nxt = RESP;
                    end else begin
                        w_mem_addr_nxt = bus.addr;
                        w_state_nxt    = READ;
                    end
                end else if (r_count != '0) begin
                    // Head entry cannot be overwritten while it is in
                    // flight: it stays valid until its ack.
                    w_mem_addr_nxt  = r_ent_addr[r_head];
                    w_mem_wdata_nxt = r_ent_data[r_head];
                    w_state_nxt     = WRITE;
                end
            end
            WRITE: begin
                if (bus.mem_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            READ: begin
                if (bus.mem_ack) begin
                    w_rdata_nxt = bus.mem_rdata;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from registered state, so reset clears them at once
    // ------------------------------------------------------------------
    assign bus.mem_req   = (r_state == WRITE) || (r_state == READ);
    assign bus.mem_we    = (r_state == WRITE);
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.rvalid    = (r_state == RESP);
    assign bus.rdata     = r_rdata;
    assign bus.wr_stall  = w_full;
    assign bus.wb_empty  = (r_count == '0) && (r_state != WRITE);

endmodule

// File: tb/tb_cache_write_buffer.sv
// tb_cache_write_buffer
//   Directed bench for cache_write_buffer (DEPTH=4): reset values, read
//   miss latency, FIFO full/stall and drain order, forwarding from buffered
//   and same-cycle writes, read priority over draining, and asynchronous
//   reset during a write.
module tb_cache_write_buffer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int bad_rd   = 0;
    logic mon_en = 1'b0;

    cache_write_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cache_write_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Counts memory read accesses while the forwarding test is active.
    always @(posedge clk) begin
        if (mon_en && bus.mem_req && !bus.mem_we) bad_rd++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !bus.mem_req; i++) tick();
        check({tag, "_req"}, 32'(bus.mem_req), 32'd1);
    endtask

    // Wait for the next memory access, check it, and acknowledge it for one cycle.
    task automatic serve(input string tag, input logic we_exp,
                         input logic [31:0] a_exp, input logic [31:0] d_exp,
                         input logic [31:0] rd);
        wait_req(tag);
        check({tag, "_we"}, 32'(bus.mem_we), 32'(we_exp));
        check({tag, "_addr"}, bus.mem_addr, a_exp);
        if (we_exp) check({tag, "_wdata"}, bus.mem_wdata, d_exp);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        tick();
        bus.mem_ack   = 1'b0;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d);
        bus.write_req = 1'b1;
        bus.addr      = a;
        bus.wdata     = d;
        tick();
        bus.write_req = 1'b0;
    endtask

    initial begin
        bus.read_req  = 1'b0;
        bus.write_req = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;

        // ---------------- reset values ----------------
        #1;
        check("rst_mem_req",  32'(bus.mem_req),  32'd0);
        check("rst_mem_we",   32'(bus.mem_we),   32'd0);
        check("rst_mem_addr", bus.mem_addr,      32'd0);
        check("rst_rvalid",   32'(bus.rvalid),   32'd0);
        check("rst_rdata",    bus.rdata,         32'd0);
        check("rst_stall",    32'(bus.wr_stall), 32'd0);
        check("rst_empty",    32'(bus.wb_empty), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // ---------------- read miss, ack in 2nd mem_req cycle ----------------
        bus.read_req = 1'b1;
        bus.addr     = 32'h100;
        tick();
        check("miss_req",  32'(bus.mem_req), 32'd1);
        check("miss_we",   32'(bus.mem_we),  32'd0);
        check("miss_addr", bus.mem_addr,     32'h100);
        tick();
        check("miss_rv_early", 32'(bus.rvalid), 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        tick();
        bus.mem_ack  = 1'b0;
        check("miss_rvalid", 32'(bus.rvalid), 32'd1);
        check("miss_rdata",  bus.rdata,       32'hDEADBEEF);
        check("miss_req_off", 32'(bus.mem_req), 32'd0);
        bus.read_req = 1'b0;
        tick();
        check("miss_rv_once", 32'(bus.rvalid), 32'd0);
        tick();

        // ---------------- fill to full, stall, drain order ----------------
        bus.write_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.addr  = 32'h10 + 32'(4 * i);
            bus.wdata = 32'hA000 + 32'(i);
            tick();
        end
        check("full_stall", 32'(bus.wr_stall), 32'd1);
        check("full_empty", 32'(bus.wb_empty), 32'd0);
        bus.addr  = 32'h20;
        bus.wdata = 32'hA004;
        tick();
        check("full_stall_hold", 32'(bus.wr_stall), 32'd1);
        check("drain0_addr",  bus.mem_addr,   32'h10);
        check("drain0_wdata", bus.mem_wdata,  32'hA000);
        check("drain0_we",    32'(bus.mem_we), 32'd1);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("ack_unstall", 32'(bus.wr_stall), 32'd0);
        check("ack_gap",     32'(bus.mem_req),  32'd0);
        tick();
        bus.write_req = 1'b0;
        check("fifth_in", 32'(bus.wr_stall), 32'd1);
        for (int i = 1; i < 5; i++) begin
            serve($sformatf("drain%0d", i), 1'b1, 32'h10 + 32'(4 * i), 32'hA000 + 32'(i), 32'h0);
        end
        check("drain_empty", 32'(bus.wb_empty), 32'd1);
        tick();

        // ---------------- forward youngest buffered write ----------------
        put(32'h50, 32'h5050);
        tick();
        check("fwd_drain_busy", bus.mem_addr, 32'h50);
        put(32'h40, 32'h1111);
        put(32'h40, 32'h2222);
        bus.read_req = 1'b1;
        bus.addr     = 32'h40;
        mon_en       = 1'b1;
        tick();
        check("fwd_wait", 32'(bus.rvalid), 32'd0);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("fwd_idle", 32'(bus.rvalid), 32'd0);
        tick();
        check("fwd_rvalid", 32'(bus.rvalid), 32'd1);
        check("fwd_rdata",  bus.rdata,       32'h2222);
        bus.read_req = 1'b0;
        tick();
        serve("fwd_d0", 1'b1, 32'h40, 32'h1111, 32'h0);
        serve("fwd_d1", 1'b1, 32'h40, 32'h2222, 32'h0);
        mon_en = 1'b0;
        check("fwd_no_memrd", 32'(bad_rd), 32'd0);
        tick();

        // ---------------- read overtakes remaining drains ----------------
        put(32'h60, 32'hB060);
        put(32'h64, 32'hB064);
        put(32'h68, 32'hB068);
        bus.read_req = 1'b1;
        bus.addr     = 32'h80;
        serve("prio0", 1'b1, 32'h60, 32'hB060, 32'h0);
        serve("prio1", 1'b0, 32'h80, 32'h0, 32'h12345678);
        check("prio_rvalid", 32'(bus.rvalid), 32'd1);
        check("prio_rdata",  bus.rdata,       32'h12345678);
        bus.read_req = 1'b0;
        serve("prio2", 1'b1, 32'h64, 32'hB064, 32'h0);
        serve("prio3", 1'b1, 32'h68, 32'hB068, 32'h0);
        check("prio_empty", 32'(bus.wb_empty), 32'd1);
        tick();

        // ---------------- same-cycle write + read ----------------
        bus.write_req = 1'b1;
        bus.read_req  = 1'b1;
        bus.addr      = 32'h90;
        bus.wdata     = 32'h5A5A;
        tick();
        bus.write_req = 1'b0;
        check("same_rvalid", 32'(bus.rvalid),   32'd1);
        check("same_rdata",  bus.rdata,         32'h5A5A);
        check("same_noreq",  32'(bus.mem_req),  32'd0);
        check("same_buffered", 32'(bus.wb_empty), 32'd0);
        bus.read_req = 1'b0;
        tick();
        serve("same_drain", 1'b1, 32'h90, 32'h5A5A, 32'h0);
        tick();

        // ---------------- async reset mid-WRITE ----------------
        put(32'hA0, 32'hA0A0);
        wait_req("ar");
        check("ar_we", 32'(bus.mem_we), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_mem_req", 32'(bus.mem_req),  32'd0);
        check("ar_empty",   32'(bus.wb_empty), 32'd1);
        check("ar_rvalid",  32'(bus.rvalid),   32'd0);
        check("ar_addr",    bus.mem_addr,      32'd0);
        tick();
        rst = 1'b1;
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("ar_ack_ign_req",   32'(bus.mem_req),  32'd0);
        check("ar_ack_ign_empty", 32'(bus.wb_empty), 32'd1);
        tick();
        check("ar_stays_idle", 32'(bus.mem_req), 32'd0);
        check("ar_rv_quiet",   32'(bus.rvalid),  32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        n_errors++;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
